// File: rtl/prng_mask_gen.sv
// prng_mask_gen: LFSR mask-word generator (in: clk, rst, en, seed_load, seed_in, mask_ready; out: mask_data, mask_valid, state_o)
module prng_mask_gen #(
  parameter int WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS = 4'b1100,
  parameter logic [WIDTH-1:0] SEED = 4'b0001,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [OUT_W-1:0] mask_data,
  output logic             mask_valid,
  input  logic             mask_ready,
  output logic [WIDTH-1:0] state_o
);
  localparam int CW = $clog2(OUT_W + 1);
  logic [WIDTH-1:0] state_q, state_d;
  logic [OUT_W-1:0] col_q, col_d, data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, fb, col_full, transfer, step;
  always_comb begin
    fb = ^(state_q & TAPS);
    col_full = cnt_q == CW'(OUT_W);
    transfer = col_full & (~valid_q | mask_ready);
    step = en & ~seed_load & (~col_full | transfer);
    state_d = seed_load ? (seed_in == '0 ? SEED : seed_in) : step ? ((state_q << 1) | WIDTH'(fb)) : state_q;
    col_d = seed_load ? '0 : step ? ((col_q << 1) | OUT_W'(fb)) : col_q;
    cnt_d = seed_load ? '0 : transfer ? CW'(step) : cnt_q + CW'(step);
    data_d = (~seed_load & transfer) ? col_q : data_q;
    valid_d = ~seed_load & (transfer | (valid_q & ~mask_ready));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEED;
      col_q <= '0;
      cnt_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      valid_q <= valid_d;
    end
  end
  assign mask_data = data_q;
  assign mask_valid = valid_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_prng_mask_gen.sv
// tb_prng_mask_gen: randomized and directed checks of prng_mask_gen against a queue-based reference model
module tb_prng_mask_gen;
  localparam logic [3:0] TAPS = 4'b1100;
  logic clk = 0, rst = 1, en = 0, seed_load = 0, mask_ready = 0;
  logic [3:0] seed_in = 0;
  logic [3:0] mask_data, state_o;
  logic mask_valid;
  int errors = 0, checks = 0;
  logic [3:0] m_state = 4'b0001, m_data = 0;
  bit m_valid = 0;
  bit m_col[$];

  always #5 clk = ~clk;

  prng_mask_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .OUT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed_in(seed_in),
    .mask_data(mask_data), .mask_valid(mask_valid), .mask_ready(mask_ready), .state_o(state_o)
  );

  task automatic model_update();
    bit full, xfer, fb;
    logic [3:0] w;
    if (rst) begin
      m_state = 4'b0001; m_col.delete(); m_data = 0; m_valid = 0;
    end else if (seed_load) begin
      m_state = (seed_in == 0) ? 4'b0001 : seed_in; m_col.delete(); m_valid = 0;
    end else begin
      full = m_col.size() == 4;
      xfer = full && (!m_valid || mask_ready);
      if (xfer) begin
        w = 0;
        foreach (m_col[i]) w = {w[2:0], m_col[i]};
        m_data = w; m_valid = 1; m_col.delete();
      end else if (m_valid && mask_ready) m_valid = 0;
      if (en && (!full || xfer)) begin
        fb = 1'($countones(m_state & TAPS) % 2);
        m_col.push_back(fb);
        m_state = {m_state[2:0], fb};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; seed_load = 0; mask_ready = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; en = 1; mask_ready = 1; seed_load = 0;
    tick(); tick();
    if (state_o !== 4'b0001) begin errors++; $display("FAIL reset_state got=%h exp=1", state_o); end checks++;
    if (mask_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", mask_valid); end checks++;
    if (mask_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", mask_data); end checks++;
    rst = 0; en = 0; mask_ready = 0;
  endtask

  task automatic test_first_words();
    logic [3:0] exp_seq[9] = '{4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB};
    bit ev;
    do_reset();
    en = 1; mask_ready = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      ev = (i == 4) || (i == 8);
      if (state_o !== exp_seq[i]) begin errors++; $display("FAIL first_state[%0d] got=%h exp=%h", i, state_o, exp_seq[i]); end checks++;
      if (mask_valid !== ev) begin errors++; $display("FAIL first_valid[%0d] got=%b exp=%b", i, mask_valid, ev); end checks++;
      if (ev && mask_data !== (i == 4 ? 4'h3 : 4'h5)) begin errors++; $display("FAIL first_data[%0d] got=%h", i, mask_data); end
      if (ev) checks++;
      if (mask_data !== m_data) begin errors++; $display("FAIL first_model_data[%0d] got=%h exp=%h", i, mask_data, m_data); end checks++;
    end
  endtask

  task automatic test_period();
    logic [3:0] seen[$];
    bit dup;
    do_reset();
    en = 1; mask_ready = 1;
    seen.push_back(state_o);
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (state_o === 4'h0) begin errors++; $display("FAIL period_zero step=%0d got=%h exp=nonzero", i, state_o); end checks++;
      if (i < 15) begin
        dup = 0;
        foreach (seen[j]) if (seen[j] === state_o) dup = 1;
        if (dup) begin errors++; $display("FAIL period_repeat step=%0d got=%h exp=new state", i, state_o); end checks++;
        seen.push_back(state_o);
      end else begin
        if (state_o !== 4'h1) begin errors++; $display("FAIL period_return got=%h exp=1", state_o); end checks++;
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    en = 1; mask_ready = 1;
    repeat (5) tick();
    if (mask_valid !== 1'b1 || mask_data !== 4'h3) begin errors++; $display("FAIL bp_first got=%b/%h exp=1/3", mask_valid, mask_data); end checks++;
    mask_ready = 0;
    repeat (3) tick();
    if (state_o !== 4'h5) begin errors++; $display("FAIL bp_fill_state got=%h exp=5", state_o); end checks++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (state_o !== 4'h5) begin errors++; $display("FAIL bp_stall_state[%0d] got=%h exp=5", i, state_o); end checks++;
      if (mask_valid !== 1'b1 || mask_data !== 4'h3) begin errors++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/3", i, mask_valid, mask_data); end checks++;
    end
    mask_ready = 1;
    tick();
    mask_ready = 0;
    if (mask_valid !== 1'b1 || mask_data !== 4'h5) begin errors++; $display("FAIL bp_release got=%b/%h exp=1/5", mask_valid, mask_data); end checks++;
    if (state_o !== 4'hB) begin errors++; $display("FAIL bp_resume got=%h exp=b", state_o); end checks++;
  endtask

  task automatic test_reseed();
    logic [3:0] exp_seq[4] = '{4'h1, 4'h2, 4'h4, 4'h9};
    do_reset();
    en = 1; mask_ready = 1;
    repeat (2) tick();
    seed_load = 1; seed_in = 4'h8;
    tick();
    seed_load = 0;
    if (state_o !== 4'h8 || mask_valid !== 1'b0) begin errors++; $display("FAIL reseed_load got=%h/%b exp=8/0", state_o, mask_valid); end checks++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (state_o !== exp_seq[i] || mask_valid !== 1'b0) begin errors++; $display("FAIL reseed_step[%0d] got=%h/%b exp=%h/0", i, state_o, mask_valid, exp_seq[i]); end checks++;
    end
    tick();
    if (mask_valid !== 1'b1 || mask_data !== 4'h9) begin errors++; $display("FAIL reseed_word got=%b/%h exp=1/9", mask_valid, mask_data); end checks++;
    mask_ready = 0;
    seed_load = 1; seed_in = 4'h3;
    tick();
    seed_load = 0;
    if (mask_valid !== 1'b0 || state_o !== 4'h3) begin errors++; $display("FAIL reseed_discard got=%b/%h exp=0/3", mask_valid, state_o); end checks++;
  endtask

  task automatic test_zero_seed();
    seed_load = 1; seed_in = 4'h0; en = 1;
    tick();
    seed_load = 0; mask_ready = 1;
    if (state_o !== 4'h1) begin errors++; $display("FAIL zero_seed got=%h exp=1", state_o); end checks++;
    repeat (20) begin
      tick();
      if (state_o !== m_state || mask_valid !== m_valid || mask_data !== m_data) begin
        errors++; $display("FAIL zero_seed_run got=%h/%b/%h exp=%h/%b/%h", state_o, mask_valid, mask_data, m_state, m_valid, m_data);
      end
      checks++;
    end
  endtask

  task automatic test_en_toggle();
    do_reset();
    en = 1; mask_ready = 1;
    repeat (2) tick();
    en = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (state_o !== 4'h4 || mask_valid !== 1'b0) begin errors++; $display("FAIL en_hold[%0d] got=%h/%b exp=4/0", i, state_o, mask_valid); end checks++;
    end
    en = 1;
    repeat (2) tick();
    if (mask_valid !== 1'b0 || state_o !== 4'h3) begin errors++; $display("FAIL en_refill got=%b/%h exp=0/3", mask_valid, state_o); end checks++;
    tick();
    if (mask_valid !== 1'b1 || mask_data !== 4'h3) begin errors++; $display("FAIL en_word got=%b/%h exp=1/3", mask_valid, mask_data); end checks++;
  endtask

  task automatic test_rst_priority();
    do_reset();
    en = 1; mask_ready = 1;
    repeat (5) tick();
    rst = 1; seed_load = 1; seed_in = 4'h8; mask_ready = 1;
    tick();
    if (state_o !== 4'h1 || mask_valid !== 1'b0 || mask_data !== 4'h0) begin
      errors++; $display("FAIL rst_priority got=%h/%b/%h exp=1/0/0", state_o, mask_valid, mask_data);
    end
    checks++;
    rst = 0; seed_load = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 3) != 0;
      mask_ready = $urandom_range(0, 1) != 0;
      seed_load = $urandom_range(0, 31) == 0;
      seed_in = 4'($urandom);
      rst = $urandom_range(0, 63) == 0;
      tick();
      if (state_o !== m_state) begin errors++; $display("FAIL rand_state[%0d] got=%h exp=%h", i, state_o, m_state); end checks++;
      if (mask_valid !== m_valid) begin errors++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, mask_valid, m_valid); end checks++;
      if (mask_data !== m_data) begin errors++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, mask_data, m_data); end checks++;
    end
    rst = 0; seed_load = 0;
  endtask

  initial begin
    test_reset();
    test_first_words();
    test_period();
    test_back_pressure();
    test_reseed();
    test_zero_seed();
    test_en_toggle();
    test_rst_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
